// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared types, sizes and the double-dabble step for the FND scan controller
// Purpose: constants shared by the converter and the scan top, the controller state
//          enum, and one combinational shift-add-3 step.
// Ports:   none (package).
package fnd_pkg;

  localparam int DIGITS      = 4;
  localparam int BIN_W       = 14;
  localparam int BCD_W       = 4 * DIGITS;
  localparam int MAX_DISPLAY = 9999;

  // Shown in place of the real value when the input does not fit in four digits.
  localparam logic [BCD_W-1:0] OVF_BCD = 16'h9999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  // One double-dabble iteration. Each BCD nibble >= 5 gets +3, then the
  // concatenation {bcd, bin} shifts left by one bit.
  function automatic logic [BCD_W+BIN_W-1:0] dabble_step(
    input logic [BCD_W-1:0] bcd,
    input logic [BIN_W-1:0] bin
  );
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bin, 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative 14-bit binary to 16-bit BCD converter, one bit per cycle
// Purpose: sequential double-dabble converter.
// Ports:   clk, rst     - clock, asynchronous active-high reset
//          start        - capture bin_in and clear the accumulator
//          bin_in[13:0] - value to convert
//          bcd_out[15:0]- BCD accumulator (final once done has been seen)
//          done         - high during the last of the 14 conversion steps
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic             done
);

  logic [BIN_W-1:0]       shift_q;
  logic [3:0]             step_q;
  logic                   running_q;
  logic [BCD_W+BIN_W-1:0] next_w;

  assign next_w = dabble_step(bcd_out, shift_q);

  // Marks the cycle whose step is the 14th, so the controller can leave
  // CONVERT on the same edge that completes the result.
  assign done = running_q && (step_q == 4'(BIN_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      bcd_out   <= '0;
      step_q    <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      shift_q   <= bin_in;
      bcd_out   <= '0;
      step_q    <= '0;
      running_q <= 1'b1;
    end else if (running_q) begin
      {bcd_out, shift_q} <= next_w;
      step_q             <= step_q + 4'd1;
      if (done) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - 4-digit FND scan controller with binary-to-BCD conversion
// Purpose: captures a binary value, converts it to BCD in the background and
//          multiplexes the displayed digits with optional leading-zero blanking.
// Ports:   i_clk, i_reset      - clock, asynchronous active-high reset
//          i_value[13:0]       - binary value, captured on i_load while idle
//          i_load              - single-cycle capture request
//          o_busy              - conversion or display update in progress
//          o_overflow          - last captured value was above 9999
//          o_digitSelect[1:0]  - active digit, 0 = least significant
//          o_bcd[3:0]          - BCD nibble of the active digit
//          o_en                - active digit lit
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int DIV_COUNT = 100000,
  parameter int BLANK_LZ  = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_load,
  output logic             o_busy,
  output logic             o_overflow,
  output logic [1:0]       o_digitSelect,
  output logic [3:0]       o_bcd,
  output logic             o_en
);

  localparam int PRE_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

  state_t           state_q;
  logic             ovf_pending_q;
  logic [BCD_W-1:0] disp_q;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;
  logic             start;
  logic [PRE_W-1:0] presc_q;
  logic [1:0]       sel_q;
  logic             lit;

  assign start  = (state_q == IDLE) && i_load;
  assign o_busy = (state_q != IDLE);

  bin2bcd_seq u_conv (
    .clk     (i_clk),
    .rst     (i_reset),
    .start   (start),
    .bin_in  (i_value),
    .bcd_out (conv_bcd),
    .done    (conv_done)
  );

  // The display register only changes in UPDATE, so the scan never sees a
  // half-converted value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      ovf_pending_q <= 1'b0;
      disp_q        <= '0;
      o_overflow    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_load) begin
            state_q       <= CONVERT;
            ovf_pending_q <= (i_value > 14'(MAX_DISPLAY));
          end
        end
        CONVERT: begin
          if (conv_done) state_q <= UPDATE;
        end
        UPDATE: begin
          disp_q     <= ovf_pending_q ? OVF_BCD : conv_bcd;
          o_overflow <= ovf_pending_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Free-running digit scan, independent of the conversion FSM.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q <= '0;
      sel_q   <= 2'd0;
    end else if (presc_q == PRE_W'(DIV_COUNT - 1)) begin
      presc_q <= '0;
      sel_q   <= sel_q + 2'd1;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  assign o_digitSelect = sel_q;

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    o_bcd = disp_q[3:0];
    lit   = 1'b1;
    case (sel_q)
      2'd1: begin o_bcd = disp_q[7:4];   lit = |disp_q[15:4];  end
      2'd2: begin o_bcd = disp_q[11:8];  lit = |disp_q[15:8];  end
      2'd3: begin o_bcd = disp_q[15:12]; lit = |disp_q[15:12]; end
      default: begin o_bcd = disp_q[3:0]; lit = 1'b1; end
    endcase
    o_en = (BLANK_LZ != 0) ? lit : 1'b1;
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - self-checking bench for fnd_scan_controller
module tb_fnd_scan_controller;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [13:0] i_value = '0;
  logic        i_load = 1'b0;

  logic       busy, ovf, en;
  logic [1:0] sel;
  logic [3:0] bcd;
  logic       busy_nb, ovf_nb, en_nb;
  logic [1:0] sel_nb;
  logic [3:0] bcd_nb;

  int n_assert = 0;
  int n_fail   = 0;
  int edges;
  int shown_val = 0;
  int shown_ovf = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.DIV_COUNT(DIV), .BLANK_LZ(1)) u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_value(i_value), .i_load(i_load),
    .o_busy(busy), .o_overflow(ovf), .o_digitSelect(sel), .o_bcd(bcd), .o_en(en)
  );

  fnd_scan_controller #(.DIV_COUNT(DIV), .BLANK_LZ(0)) u_dut_nb (
    .i_clk(clk), .i_reset(i_reset), .i_value(i_value), .i_load(i_load),
    .o_busy(busy_nb), .o_overflow(ovf_nb), .o_digitSelect(sel_nb), .o_bcd(bcd_nb), .o_en(en_nb)
  );

  // Rising edges seen since reset was last released.
  always @(posedge clk or posedge i_reset) begin
    if (i_reset) edges <= 0;
    else         edges <= edges + 1;
  end

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic int model_digit(input int v, input int k);
    return (v / pow10(k)) % 10;
  endfunction

  function automatic int model_lit(input int v, input int k);
    return (k == 0 || v >= pow10(k)) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int exp_busy);
    int s;
    s = (edges / DIV) % 4;
    chk({tag, ".sel"},     32'(sel),     32'(s));
    chk({tag, ".bcd"},     32'(bcd),     32'(model_digit(shown_val, s)));
    chk({tag, ".en"},      32'(en),      32'(model_lit(shown_val, s)));
    chk({tag, ".ovf"},     32'(ovf),     32'(shown_ovf));
    chk({tag, ".busy"},    32'(busy),    32'(exp_busy));
    chk({tag, ".nb_sel"},  32'(sel_nb),  32'(s));
    chk({tag, ".nb_bcd"},  32'(bcd_nb),  32'(model_digit(shown_val, s)));
    chk({tag, ".nb_en"},   32'(en_nb),   32'd1);
    chk({tag, ".nb_ovf"},  32'(ovf_nb),  32'(shown_ovf));
    chk({tag, ".nb_busy"}, 32'(busy_nb), 32'(exp_busy));
  endtask

  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle("scan", 0);
    end
  endtask

  // Load at cycle N, expect busy during N+1..N+15 with the old display still
  // shown, then the new value from N+16 on. Optionally retry a load mid-busy.
  task automatic do_load(input int v, input int inject_at, input int inject_v);
    @(negedge clk);
    check_cycle("pre", 0);
    i_value = 14'(v);
    i_load  = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      check_cycle("busy", 1);
      if (c == inject_at) begin
        i_value = 14'(inject_v);
        i_load  = 1'b1;
      end
      @(negedge clk);
      i_load = 1'b0;
    end
    shown_val = (v > 9999) ? 9999 : v;
    shown_ovf = (v > 9999) ? 1 : 0;
    check_cycle("done", 0);
  endtask

  initial begin
    #1;
    check_cycle("reset", 0);
    @(negedge clk);
    i_reset = 1'b0;
    check_cycle("release", 0);
    scan(8);

    do_load(1234, 0, 0);   scan(16);
    do_load(12000, 0, 0);  scan(16);
    do_load(7, 0, 0);      scan(16);
    do_load(5, 0, 0);      scan(16);
    do_load(0, 0, 0);      scan(16);
    do_load(1000, 0, 0);   scan(16);
    do_load(9999, 0, 0);   scan(8);
    do_load(10000, 0, 0);  scan(8);
    do_load(42, 5, 99);    scan(16);
    do_load(99, 0, 0);     scan(16);

    for (int r = 0; r < 20; r++) begin
      do_load(int'($urandom_range(0, 16383)), 0, 0);
      scan(int'($urandom_range(0, 12)));
    end

    // Reset in the middle of the scan.
    do_load(8765, 0, 0);
    scan(6);
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    shown_val = 0;
    shown_ovf = 0;
    check_cycle("rst_scan", 0);
    @(negedge clk);
    i_reset = 1'b0;
    check_cycle("rst_scan_rel", 0);
    scan(16);

    // Reset in the middle of a conversion: display must stay cleared.
    do_load(2222, 0, 0);
    scan(3);
    @(negedge clk);
    i_value = 14'd3333;
    i_load  = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_cycle("conv_busy", 1);
      @(negedge clk);
    end
    i_reset = 1'b1;
    #1;
    shown_val = 0;
    shown_ovf = 0;
    check_cycle("rst_conv", 0);
    @(negedge clk);
    i_reset = 1'b0;
    check_cycle("rst_conv_rel", 0);
    scan(24);

    do_load(6013, 0, 0);
    scan(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
